multi_channel_accumulator: RTL and testbench
============================================

Name: multi_channel_accumulator

Overview:
Parametrised, multi-channel signed accumulator with a registered two-stage pipeline.
- Each input beat carries data, a channel index and an operation (add, subtract, load, clear).
- The addressed channel's accumulator is updated and its new value is emitted as a valid-tagged output beat.
- Optional saturation and per-channel sticky overflow flags.
- Sits behind sample sources in the DSP datapath (multi-channel integrators, running sums).

Parameters:
WIDTH, 8, input data width (signed, two's complement).
ACC_WIDTH, 16, accumulator/output width; must be >= WIDTH+1.
CHANNELS, 4, number of independent accumulators; >= 2; need not be a power of two.
SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  input beat qualifier.
in_ch  in  CW=$clog2(CHANNELS)  target channel.
in_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
in_data  in  WIDTH  signed operand; ignored for CLEAR.
out_valid  out  1  one-cycle pulse per accepted beat.
out_ch  out  CW  channel of the result.
out_data  out  ACC_WIDTH  signed post-update accumulator value.
ovf  out  CHANNELS  sticky per-channel overflow flags.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: all accumulators 0, ovf all 0, out_valid 0, out_ch 0, out_data 0, stage-1 valid 0.
- No backpressure: a beat is accepted every cycle in_valid=1.
- Stage 1 registers {in_valid, in_ch, in_op, in_data}.
- Stage 2 reads the accumulator, computes, writes back, and drives the outputs.
- Latency: out_valid asserts exactly 2 cycles after the accepting edge of in_valid.
- out_ch and out_data hold their last values when out_valid=0.
- Back-to-back beats to the same channel on consecutive cycles use the updated value; no bubbles and no stale reads. This is inherent, since the read and write-back both happen in stage 2.
- Arithmetic:
  - Sign-extend in_data to ACC_WIDTH+1.
  - ADD: acc + x. SUB: acc - x.
  - LOAD: acc = sext(x); never overflows.
  - CLEAR: acc = 0 and ovf[ch] = 0.
- Overflow is detected when the ACC_WIDTH+1 result falls outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SATURATE=1: clamp to the violated bound.
  - SATURATE=0: keep the low ACC_WIDTH bits.
  - In both modes, set ovf[ch]=1 in the same cycle out_valid asserts.
- ovf[ch] clears only on reset or CLEAR of that channel. LOAD does not clear it.
- in_ch >= CHANNELS (non-power-of-two CHANNELS): beat dropped at stage 1. No state change, no out_valid.
- Reset has priority over any in-flight beat: pipeline contents are discarded, and no out_valid occurs in the cycle after reset is released.
- Beats with in_valid=0 change nothing; in_* values are don't-care.

Decomposition:
- Shared package: op-code constants (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR) and the 2-bit op type; the channel-index width function.
- One natural sub-module, acc_sat_unit: combinational sign-extend, add/sub/load/clear select, overflow detect, clamp/wrap. Parameters: WIDTH, ACC_WIDTH, SATURATE. Outputs: next value and ovf bit.
- The top level holds the pipeline registers, the accumulator array and the ovf flags.

Test Plan:
(All tests use WIDTH=8, ACC_WIDTH=12, CHANNELS=4 unless stated.)
- Reset, then ch1 ADD 5 at cycle t and ch1 ADD -3 at t+1 -> out_valid at t+2 (ch1, 5) and t+3 (ch1, 2); ovf=0000.
- SATURATE=1: ch0 ADD 127 ×17 back-to-back -> 16th out 2032, 17th out 2047, ovf[0]=1. Then ch0 CLEAR -> out 0, ovf[0]=0.
- SATURATE=0: same stimulus as above -> 17th out -1937 (2159-4096), ovf[0]=1 and stays set through a following LOAD 1.
- Interleaved: ch2 LOAD -128, ch3 ADD 7, ch2 SUB 127, ch3 SUB -8 -> outs (2,-128), (3,7), (2,-255), (3,15); ch0 and ch1 unchanged.
- CHANNELS=3: beat with in_ch=3 -> no out_valid, no state change. Reset asserted one cycle after a valid beat -> that beat's out_valid never appears and all accumulators read 0 afterwards.

Source files
------------

// File: rtl/multi_channel_accumulator_pkg.sv
// Shared definitions for the multi-channel accumulator: op codes and the
// channel-index width helper.
package multi_channel_accumulator_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_channel_accumulator_acc_sat_unit.sv
// Combinational update of one accumulator: sign-extend, op select, overflow
// detect and clamp/wrap of the ACC_WIDTH+1 bit result.
module acc_sat_unit
  import multi_channel_accumulator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SATURATE  = 1
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  op_t                         op,
  input  logic signed [WIDTH-1:0]     data,
  output logic signed [ACC_WIDTH-1:0] next_acc,
  output logic                        ovf
);

  localparam int XW = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};

  logic signed [XW-1:0] acc_x;
  logic signed [XW-1:0] data_x;
  logic signed [XW-1:0] res;

  assign acc_x  = {acc[ACC_WIDTH-1], acc};
  assign data_x = {{(XW-WIDTH){data[WIDTH-1]}}, data};

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:   res = acc_x + data_x;
      OP_SUB:   res = acc_x - data_x;
      OP_LOAD:  res = data_x;
      OP_CLEAR: res = '0;
      default:  res = '0;
    endcase
  end

  // The extended result is exact, so the two top bits disagree exactly when
  // the value does not fit in ACC_WIDTH bits.
  assign ovf = res[XW-1] ^ res[XW-2];

  always_comb begin
    next_acc = res[ACC_WIDTH-1:0];
    if (ovf && (SATURATE != 0)) begin
      next_acc = res[XW-1] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/multi_channel_accumulator.sv
// Multi-channel signed accumulator with a two-stage pipeline: stage 1 registers
// the beat, stage 2 reads, updates and writes back the addressed channel.
//
// Handshake: in_valid qualifies a beat and there is no ready -- every valid
// beat to an existing channel is taken. out_valid pulses once per taken beat,
// two cycles later; out_ch/out_data hold their last values otherwise.
module multi_channel_accumulator
  import multi_channel_accumulator_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int ACC_WIDTH = 16,
  parameter  int CHANNELS  = 4,
  parameter  int SATURATE  = 1,
  localparam int CW        = ch_width(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [CW-1:0]               in_ch,
  input  logic [1:0]                  in_op,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  output logic [CW-1:0]               out_ch,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]         ovf
);

  logic                        s1_valid;
  logic [CW-1:0]               s1_ch;
  op_t                         s1_op;
  logic signed [WIDTH-1:0]     s1_data;
  logic                        ch_ok;

  logic signed [ACC_WIDTH-1:0] acc [CHANNELS];
  logic signed [ACC_WIDTH-1:0] cur_acc;
  logic signed [ACC_WIDTH-1:0] nxt_acc;
  logic                        nxt_ovf;

  // With a power-of-two channel count every index is valid.
  if ((1 << CW) == CHANNELS) begin : g_pow2
    assign ch_ok = 1'b1;
  end else begin : g_npow2
    assign ch_ok = (int'(in_ch) < CHANNELS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_op    <= OP_ADD;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid && ch_ok;
      s1_ch    <= in_ch;
      s1_op    <= op_t'(in_op);
      s1_data  <= in_data;
    end
  end

  assign cur_acc = acc[s1_ch];

  acc_sat_unit #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_acc_sat_unit (
    .acc      (cur_acc),
    .op       (s1_op),
    .data     (s1_data),
    .next_acc (nxt_acc),
    .ovf      (nxt_ovf)
  );

  // Read and write-back share stage 2, so consecutive beats to one channel
  // always see the freshly written value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
      end
      ovf       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        acc[s1_ch] <= nxt_acc;
        out_ch     <= s1_ch;
        out_data   <= nxt_acc;
        if (s1_op == OP_CLEAR) begin
          ovf[s1_ch] <= 1'b0;
        end else if (nxt_ovf) begin
          ovf[s1_ch] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Directed bench for multi_channel_accumulator: three instances (saturating,
// wrapping, three-channel) checked through per-instance expected queues.
module tb_multi_channel_accumulator;
  import multi_channel_accumulator_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // unit 0: SATURATE=1, 4 ch; unit 1: SATURATE=0, 4 ch; unit 2: SATURATE=1, 3 ch
  logic [2:0]       v;
  logic [2:0][1:0]  ich;
  logic [2:0][1:0]  iop;
  logic [2:0][7:0]  idat;
  logic [2:0]       ov;
  logic [2:0][1:0]  och;
  logic [2:0][11:0] odat;
  logic [3:0]       ovf_a;
  logic [3:0]       ovf_b;
  logic [2:0]       ovf_c;

  multi_channel_accumulator #(.WIDTH(8), .ACC_WIDTH(12), .CHANNELS(4), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(v[0]), .in_ch(ich[0]), .in_op(iop[0]),
    .in_data(idat[0]), .out_valid(ov[0]), .out_ch(och[0]), .out_data(odat[0]), .ovf(ovf_a));

  multi_channel_accumulator #(.WIDTH(8), .ACC_WIDTH(12), .CHANNELS(4), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(v[1]), .in_ch(ich[1]), .in_op(iop[1]),
    .in_data(idat[1]), .out_valid(ov[1]), .out_ch(och[1]), .out_data(odat[1]), .ovf(ovf_b));

  multi_channel_accumulator #(.WIDTH(8), .ACC_WIDTH(12), .CHANNELS(3), .SATURATE(1)) u_ch3 (
    .clk(clk), .reset(reset), .in_valid(v[2]), .in_ch(ich[2]), .in_op(iop[2]),
    .in_data(idat[2]), .out_valid(ov[2]), .out_ch(och[2]), .out_data(odat[2]), .ovf(ovf_c));

  // scoreboard: {due cycle, channel, data}
  logic [45:0] exp_q0[$];
  logic [45:0] exp_q1[$];
  logic [45:0] exp_q2[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon(input int u, input logic [1:0] ch, input logic [11:0] d);
    logic [45:0] e;
    logic [45:0] a;
    a = {32'(cyc), ch, d};
    e = '0;
    case (u)
      0: if (exp_q0.size() > 0) e = exp_q0.pop_front(); else e = '1;
      1: if (exp_q1.size() > 0) e = exp_q1.pop_front(); else e = '1;
      default: if (exp_q2.size() > 0) e = exp_q2.pop_front(); else e = '1;
    endcase
    if (e == '1) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_out u%0d: got ch=%0d data=%0d at cycle %0d, expected none",
               u, ch, $signed(d), cyc);
    end else begin
      chk($sformatf("out u%0d {cyc,ch,data}", u), 64'(a), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (ov[0]) mon(0, och[0], odat[0]);
    if (ov[1]) mon(1, och[1], odat[1]);
    if (ov[2]) mon(2, och[2], odat[2]);
  end

  // driver tasks
  task automatic beat(input int u, input int c, input logic [1:0] o, input int data,
                      input bit expect_out, input int ed);
    logic [45:0] e;
    v[u]    = 1'b1;
    ich[u]  = c[1:0];
    iop[u]  = o;
    idat[u] = data[7:0];
    if (expect_out) begin
      e = {32'(cyc + 2), c[1:0], ed[11:0]};
      case (u)
        0: exp_q0.push_back(e);
        1: exp_q1.push_back(e);
        default: exp_q2.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int u, input int n);
    v[u] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    v = '0; ich = '0; iop = '0; idat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(ov), 64'(0));
    chk("reset out_ch", 64'(och[0]), 64'(0));
    chk("reset out_data", 64'(odat[0]), 64'(0));
    chk("reset ovf_a", 64'(ovf_a), 64'(0));
    chk("reset ovf_b", 64'(ovf_b), 64'(0));
    chk("reset ovf_c", 64'(ovf_c), 64'(0));
    reset = 1'b0;

    // basic back-to-back to one channel
    beat(0, 1, OP_ADD, 5, 1, 5);
    beat(0, 1, OP_ADD, -3, 1, 2);
    idle(0, 3);
    chk("basic ovf_a", 64'(ovf_a), 64'(0));

    // positive saturation: 16*127 = 2032, 17th clamps to 2047
    for (int k = 1; k <= 17; k++) beat(0, 0, OP_ADD, 127, 1, (k < 17) ? k * 127 : 2047);
    idle(0, 3);
    chk("sat ovf_a", 64'(ovf_a), 64'(4'b0001));
    chk("hold out_data", 64'(odat[0]), 64'(12'd2047));
    chk("hold out_ch", 64'(och[0]), 64'(0));
    beat(0, 0, OP_CLEAR, 99, 1, 0);
    idle(0, 3);
    chk("clear ovf_a", 64'(ovf_a), 64'(0));

    // interleaved channels, then confirm ch1/ch0 untouched
    beat(0, 2, OP_LOAD, -128, 1, -128);
    beat(0, 3, OP_ADD, 7, 1, 7);
    beat(0, 2, OP_SUB, 127, 1, -255);
    beat(0, 3, OP_SUB, -8, 1, 15);
    beat(0, 1, OP_ADD, 0, 1, 2);
    beat(0, 0, OP_ADD, 0, 1, 0);
    idle(0, 3);
    chk("interleave ovf_a", 64'(ovf_a), 64'(0));

    // wrap mode: 2159 - 4096 = -1937; LOAD keeps the sticky flag
    for (int k = 1; k <= 17; k++) beat(1, 0, OP_ADD, 127, 1, (k < 17) ? k * 127 : -1937);
    idle(1, 3);
    chk("wrap ovf_b", 64'(ovf_b), 64'(4'b0001));
    beat(1, 0, OP_LOAD, 1, 1, 1);
    idle(1, 3);
    chk("load keeps ovf_b", 64'(ovf_b), 64'(4'b0001));

    // three channels: index 3 is dropped
    beat(2, 1, OP_ADD, 9, 1, 9);
    beat(2, 3, OP_ADD, 50, 0, 0);
    beat(2, 1, OP_ADD, 0, 1, 9);
    idle(2, 3);
    chk("drop ovf_c", 64'(ovf_c), 64'(0));

    // reset one cycle after a valid beat discards it
    beat(2, 2, OP_ADD, 20, 0, 0);
    v[2] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    beat(2, 0, OP_ADD, 0, 1, 0);
    beat(2, 1, OP_ADD, 0, 1, 0);
    beat(2, 2, OP_ADD, 0, 1, 0);
    idle(2, 4);
    chk("post-reset ovf_c", 64'(ovf_c), 64'(0));

    chk("q0 drained", 64'(exp_q0.size()), 64'(0));
    chk("q1 drained", 64'(exp_q1.size()), 64'(0));
    chk("q2 drained", 64'(exp_q2.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
